// File: rtl/ads1672_mc_capture.sv
// Multi-lane ADS1672 serial capture: frame-sync/clock generation, per-lane shifters, sample FIFO, Avalon-MM regs.
// Optional macro ADS1672_MC_SIGN_EXT_EN: sign-extend stored samples (default: zero-extend).
module ads1672_mc_capture #(
  parameter int NUM_CH         = 2,
  parameter int ADC_DATA_WIDTH = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int CLK_DIV        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  irq,
  output logic                  clkx,
  output logic                  fsx,
  input  logic [NUM_CH-1:0]     drr,
  input  logic                  drdy_n,
  output logic                  start
);
  localparam int HALF = CLK_DIV / 2;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int DW   = $clog2(HALF + 1);
  localparam int BW   = $clog2(ADC_DATA_WIDTH + 1);
  localparam int SW   = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_SYNC = 3'd2, S_SHIFT = 3'd3, S_STORE = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [DW-1:0]             div_q, div_d;
  logic                      clkx_q, clkx_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [SW-1:0]             store_q, store_d;
  logic                      drop_q, drop_d;
  logic                      shift_en;
  logic [1:0]                rst_sync_q;
  logic [2:0]                drdy_q;
  logic                      en_q, cont_q, irq_en_q, arm_q, flush_q, ovf_q, missed_q;
  logic [ADC_DATA_WIDTH-1:0] shift_q [NUM_CH];
  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]             level_q;
  logic [DATA_WIDTH-1:0]     readdata_q, rdata_d, push_data;
  logic [ADC_DATA_WIDTH-1:0] sample;
  logic [31:0]               status_w, ctrl_w;

  wire run      = rst_sync_q[1];
  wire trigger  = drdy_q[2] & ~drdy_q[1];
  wire tick     = (div_q == DW'(HALF - 1));
  wire empty    = (level_q == '0);
  wire full     = (level_q == LW'(FIFO_DEPTH));
  wire no_room  = (int'(level_q) > FIFO_DEPTH - NUM_CH);
  wire ctrl_wr  = write && (address == 2'd2);
  wire stat_wr  = write && (address == 2'd1);
  wire push     = (state_q == S_STORE) && !drop_q && en_q && !flush_q;
  wire pop      = read && (address == 2'd0) && !empty && !flush_q;
  wire ovf_set  = (state_q == S_SHIFT) && (state_d == S_STORE) && no_room;
  wire miss_set = trigger && (state_q inside {S_SYNC, S_SHIFT, S_STORE});
  wire unused_wdata = &{1'b0, writedata[DATA_WIDTH-1:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
      drdy_q     <= 3'b111;
      state_q    <= S_IDLE;
      div_q      <= '0;
      clkx_q     <= 1'b0;
      bit_q      <= '0;
      store_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      drdy_q     <= {drdy_q[1:0], drdy_n};
      state_q    <= state_d;
      div_q      <= div_d;
      clkx_q     <= clkx_d;
      bit_q      <= bit_d;
      store_q    <= store_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    clkx_d   = 1'b0;
    bit_d    = bit_q;
    store_d  = '0;
    drop_d   = drop_q;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: if (en_q && (cont_q || arm_q)) state_d = S_WAIT;
      S_WAIT: begin
        bit_d = '0;
        if (trigger) state_d = S_SYNC;
      end
      S_SYNC, S_SHIFT: begin
        div_d    = tick ? '0 : div_q + 1'b1;
        clkx_d   = tick ? ~clkx_q : clkx_q;
        shift_en = (state_q == S_SHIFT) && tick && !clkx_q;
        // a falling clkx edge closes one serial period
        if (tick && clkx_q) begin
          if (state_q == S_SYNC) begin
            state_d = S_SHIFT;
          end else if (bit_q == BW'(ADC_DATA_WIDTH - 1)) begin
            state_d = S_STORE;
            drop_d  = no_room;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STORE: begin
        store_d = store_q + 1'b1;
        if (store_q == SW'(NUM_CH - 1)) state_d = cont_q ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_q || !run) begin
      state_d = S_IDLE;
      clkx_d  = 1'b0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shift_q[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < NUM_CH; i++) shift_q[i] <= {shift_q[i][ADC_DATA_WIDTH-2:0], drr[i]};
    end
  end

  always_comb begin
    sample = '0;
    for (int i = 0; i < NUM_CH; i++) if (store_q == SW'(i)) sample = shift_q[i];
`ifdef ADS1672_MC_SIGN_EXT_EN
    push_data = {DATA_WIDTH{sample[ADC_DATA_WIDTH-1]}};
`else
    push_data = '0;
`endif
    push_data[ADC_DATA_WIDTH-1:0] = sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0; cont_q <= 1'b0; irq_en_q <= 1'b0;
      arm_q <= 1'b0; flush_q <= 1'b0; ovf_q <= 1'b0; missed_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q     <= writedata[0];
        cont_q   <= writedata[1];
        irq_en_q <= writedata[4];
      end
      arm_q   <= ctrl_wr && writedata[2];
      flush_q <= ctrl_wr && writedata[3];
      // new events win over a coincident clear so none are lost
      if (ovf_set) ovf_q <= 1'b1;
      else if (stat_wr && writedata[2]) ovf_q <= 1'b0;
      if (miss_set) missed_q <= 1'b1;
      else if (stat_wr && writedata[3]) missed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      readdata_q <= '0;
    end else begin
      if (flush_q) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop) level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
      readdata_q <= rdata_d;
    end
  end

  assign status_w = {13'd0, state_q, 8'(level_q), 4'd0, missed_q, ovf_q, full, empty};
  assign ctrl_w   = {27'd0, irq_en_q, flush_q, arm_q, cont_q, en_q};

  always_comb begin
    rdata_d = '0;
    if (read) begin
      case (address)
        2'd0:    if (!empty) rdata_d = mem_q[rd_ptr_q];
        2'd1:    rdata_d = DATA_WIDTH'(status_w);
        2'd2:    rdata_d = DATA_WIDTH'(ctrl_w);
        default: rdata_d = '0;
      endcase
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_en_q & ((level_q >= LW'(NUM_CH)) | ovf_q);
  assign clkx     = clkx_q;
  assign fsx      = (state_q == S_SYNC);
  assign start    = en_q;
endmodule
